// File: rtl/enet_ctrl_pkg.sv
// Shared definitions for the Ethernet controller command interface.
// Used by both the TX and RX controllers.
package enet_ctrl_pkg;

    // Command codes on comm_type
    localparam logic [1:0] COMMAND_READ  = 2'd0;
    localparam logic [1:0] COMMAND_WRITE = 2'd1;
    localparam logic [1:0] COMMAND_TX    = 2'd2;
    localparam logic [1:0] COMMAND_RX    = 2'd3;

    // Post-command delay codes
    localparam logic [2:0] NO_DELAY = 3'd0;

    // Controller register addresses
    localparam logic [7:0] REG_NONE   = 8'h00;
    localparam logic [7:0] REG_ISR    = 8'hFE;
    localparam logic [7:0] REG_MRCMDX = 8'hF0;
    localparam logic [7:0] REG_MRCMD  = 8'hF2;

    // Bus width reported by the io-mode bit
    localparam logic IO_MODE_16 = 1'b0;
    localparam logic IO_MODE_8  = 1'b1;

    // Value written to the ISR to acknowledge the RX interrupt
    localparam logic [15:0] ISR_CLEAR_RX = 16'h0001;

    // RX controller states; ISSUE/WAIT_ENET are shared by every access
    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_GRANT,
        S_ISSUE,
        S_WAIT_ENET,
        S_RD_IOMODE,
        S_RD_MRCMDX0,
        S_RD_MRCMDX,
        S_RD_HDR,
        S_RD_LEN,
        S_RD_DATA,
        S_CLR_ISR,
        S_DONE_BUS
    } rx_state_t;

endpackage

// File: rtl/rx_controller_if.sv
// Bus/handshake bundle between the RX controller, the arbitrator,
// the Ethernet controller command port and the payload consumer.
interface rx_controller_if #(
    parameter int LEN_W = 11
);
    logic             enet_rdy_in;
    logic             rx_int_in;
    logic             rx_grant_in;
    logic             rx_req_out;
    logic [7:0]       rx_addr_out;
    logic [15:0]      rx_dataw_out;
    logic [15:0]      rx_datar_in;
    logic [2:0]       rx_post_command_delay_out;
    logic             rx_start_comm_out;
    logic [1:0]       rx_comm_type_out;
    logic [15:0]      rx_packet_data_out;
    logic             rx_packet_data_valid_out;
    logic [LEN_W-1:0] rx_packet_length_out;
    logic             rx_complete_out;
    logic             rx_error_out;

    // Controller side
    modport master (
        input  enet_rdy_in, rx_int_in, rx_grant_in, rx_datar_in,
        output rx_req_out, rx_addr_out, rx_dataw_out, rx_post_command_delay_out,
               rx_start_comm_out, rx_comm_type_out, rx_packet_data_out,
               rx_packet_data_valid_out, rx_packet_length_out,
               rx_complete_out, rx_error_out
    );

    // Environment side (arbitrator, Ethernet controller, consumer)
    modport slave (
        output enet_rdy_in, rx_int_in, rx_grant_in, rx_datar_in,
        input  rx_req_out, rx_addr_out, rx_dataw_out, rx_post_command_delay_out,
               rx_start_comm_out, rx_comm_type_out, rx_packet_data_out,
               rx_packet_data_valid_out, rx_packet_length_out,
               rx_complete_out, rx_error_out
    );
endinterface

// File: rtl/rx_byte_assembler.sv
// Builds 16-bit payload words from controller reads and counts words
// down to the end of the frame. In 16-bit mode the bytes are swapped so
// the first wire byte lands in [15:8]; in 8-bit mode two reads form a word.
module rx_byte_assembler #(
    parameter int LEN_W = 11
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             i_ioMode8,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_length,
    input  logic             i_capture,
    input  logic             i_suppress,
    input  logic [15:0]      i_datar,
    output logic [15:0]      o_word,
    output logic             o_valid,
    output logic             o_last
);
    localparam logic [LEN_W-1:0] ONE_WORD = LEN_W'(1);

    logic [LEN_W-1:0] r_wordsLeft;
    logic [7:0]       r_hiByte;
    logic             r_hiPending;
    logic [15:0]      r_word;
    logic             r_valid;

    logic [LEN_W:0]   w_lenPlusOne;
    logic             w_wordDone;
    logic [15:0]      w_assembled;

    assign w_lenPlusOne = {1'b0, i_length} + {{LEN_W{1'b0}}, 1'b1};

    // A capture finishes a word immediately in 16-bit mode, or on the second byte in 8-bit mode
    always_comb begin
        w_wordDone  = i_capture && (!i_ioMode8 || r_hiPending);
        w_assembled = i_ioMode8 ? {r_hiByte, i_datar[7:0]} : {i_datar[7:0], i_datar[15:8]};
    end

    assign o_last  = w_wordDone && (r_wordsLeft == ONE_WORD);
    assign o_word  = r_word;
    assign o_valid = r_valid;

    // Word countdown, byte pairing and the one-cycle valid pulse after each completed word
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wordsLeft <= '0;
            r_hiByte    <= 8'h00;
            r_hiPending <= 1'b0;
            r_word      <= 16'h0000;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_load) begin
                r_wordsLeft <= w_lenPlusOne[LEN_W:1];
                r_hiPending <= 1'b0;
            end else if (w_wordDone) begin
                r_word      <= w_assembled;
                r_valid     <= !i_suppress;
                r_wordsLeft <= r_wordsLeft - ONE_WORD;
                r_hiPending <= 1'b0;
            end else if (i_capture) begin
                r_hiByte    <= i_datar[7:0];
                r_hiPending <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/rx_controller.sv
// RX controller: on an RX interrupt, wins the bus, polls MRCMDX, reads
// header/length/payload through MRCMD, streams words to the user, drains
// queued frames, then clears the ISR and releases the bus.
module rx_controller #(
    parameter int MAX_LEN = 1536,
    parameter int LEN_W   = 11
) (
    input logic            Clock,
    input logic            Reset,
    rx_controller_if.master bus
);
    import enet_ctrl_pkg::*;

    localparam logic [15:0] MAX_LEN_16 = 16'(MAX_LEN);

    rx_state_t        r_state, r_ret;
    logic             r_ioMode, r_byteSel, r_complete, r_error;
    logic [7:0]       r_lenLow, r_status;
    logic [LEN_W-1:0] r_length;

    rx_state_t        w_nextState, w_nextRet;
    logic             w_nextIoMode, w_nextByteSel, w_nextComplete, w_nextError;
    logic [7:0]       w_nextLenLow, w_nextStatus;
    logic [LEN_W-1:0] w_nextLength;
    logic [15:0]      w_fullLen, w_word;
    logic             w_load, w_capture, w_valid, w_last;
    logic [7:0]       w_addr;
    logic [1:0]       w_type;
    logic [15:0]      w_dataw;

    rx_byte_assembler #(.LEN_W(LEN_W)) u_assembler (
        .Clock      (Clock),
        .Reset      (Reset),
        .i_ioMode8  (r_ioMode == IO_MODE_8),
        .i_load     (w_load),
        .i_length   (w_fullLen[LEN_W-1:0]),
        .i_capture  (w_capture),
        .i_suppress (r_status != 8'h00),
        .i_datar    (bus.rx_datar_in),
        .o_word     (w_word),
        .o_valid    (w_valid),
        .o_last     (w_last)
    );

    // State and return-state registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_ret   <= S_IDLE;
        end else begin
            r_state <= w_nextState;
            r_ret   <= w_nextRet;
        end
    end

    // Frame context registers and the completion pulse
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ioMode   <= IO_MODE_16;
            r_byteSel  <= 1'b0;
            r_lenLow   <= 8'h00;
            r_status   <= 8'h00;
            r_length   <= '0;
            r_complete <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_ioMode   <= w_nextIoMode;
            r_byteSel  <= w_nextByteSel;
            r_lenLow   <= w_nextLenLow;
            r_status   <= w_nextStatus;
            r_length   <= w_nextLength;
            r_complete <= w_nextComplete;
            r_error    <= w_nextError;
        end
    end

    // Next-state logic; each result state consumes datar and queues the next access via ISSUE
    always_comb begin
        w_nextState    = r_state;
        w_nextRet      = r_ret;
        w_nextIoMode   = r_ioMode;
        w_nextByteSel  = r_byteSel;
        w_nextLenLow   = r_lenLow;
        w_nextStatus   = r_status;
        w_nextLength   = r_length;
        w_nextComplete = 1'b0;
        w_nextError    = 1'b0;
        w_load         = 1'b0;
        w_capture      = 1'b0;
        w_fullLen      = (r_ioMode == IO_MODE_8) ? {bus.rx_datar_in[7:0], r_lenLow} : bus.rx_datar_in;
        case (r_state)
            S_IDLE: if (bus.rx_int_in) w_nextState = S_WAIT_GRANT;
            S_WAIT_GRANT: if (bus.rx_grant_in) begin
                w_nextState = S_ISSUE;
                w_nextRet   = S_RD_IOMODE;
            end
            S_ISSUE: w_nextState = S_WAIT_ENET;
            S_WAIT_ENET: if (bus.enet_rdy_in) w_nextState = r_ret;
            S_RD_IOMODE: begin
                w_nextIoMode = bus.rx_datar_in[7];
                w_nextState  = S_ISSUE;
                w_nextRet    = S_RD_MRCMDX0;
            end
            S_RD_MRCMDX0: begin
                w_nextState = S_ISSUE;
                w_nextRet   = S_RD_MRCMDX;
            end
            S_RD_MRCMDX: begin
                if (bus.rx_datar_in[7:0] == 8'h00) begin
                    w_nextState = S_CLR_ISR;
                end else if (bus.rx_datar_in[7:0] == 8'h01) begin
                    w_nextState   = S_ISSUE;
                    w_nextRet     = S_RD_HDR;
                    w_nextByteSel = 1'b0;
                end else begin
                    w_nextComplete = 1'b1;
                    w_nextError    = 1'b1;
                    w_nextState    = S_CLR_ISR;
                end
            end
            S_RD_HDR: begin
                w_nextState = S_ISSUE;
                if ((r_ioMode == IO_MODE_8) && !r_byteSel) begin
                    w_nextByteSel = 1'b1;
                    w_nextRet     = S_RD_HDR;
                end else begin
                    w_nextByteSel = 1'b0;
                    w_nextStatus  = (r_ioMode == IO_MODE_8) ? bus.rx_datar_in[7:0] : bus.rx_datar_in[15:8];
                    w_nextRet     = S_RD_LEN;
                end
            end
            S_RD_LEN: begin
                w_nextState = S_ISSUE;
                if ((r_ioMode == IO_MODE_8) && !r_byteSel) begin
                    w_nextByteSel = 1'b1;
                    w_nextLenLow  = bus.rx_datar_in[7:0];
                    w_nextRet     = S_RD_LEN;
                end else begin
                    w_nextByteSel = 1'b0;
                    w_nextLength  = w_fullLen[LEN_W-1:0];
                    if ((w_fullLen == 16'h0000) || (w_fullLen > MAX_LEN_16)) begin
                        w_nextComplete = 1'b1;
                        w_nextError    = 1'b1;
                        w_nextRet      = S_RD_MRCMDX0;
                    end else begin
                        w_load    = 1'b1;
                        w_nextRet = S_RD_DATA;
                    end
                end
            end
            S_RD_DATA: begin
                w_capture   = 1'b1;
                w_nextState = S_ISSUE;
                if (w_last) begin
                    w_nextComplete = 1'b1;
                    w_nextError    = (r_status != 8'h00);
                    w_nextRet      = S_RD_MRCMDX0;
                end else begin
                    w_nextRet = S_RD_DATA;
                end
            end
            S_CLR_ISR: begin
                w_nextState = S_ISSUE;
                w_nextRet   = S_DONE_BUS;
            end
            S_DONE_BUS: w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Command address/type/data follow the access in flight, named by its return state
    always_comb begin
        w_addr  = REG_NONE;
        w_type  = COMMAND_READ;
        w_dataw = 16'h0000;
        if ((r_state == S_ISSUE) || (r_state == S_WAIT_ENET)) begin
            case (r_ret)
                S_RD_IOMODE: w_addr = REG_ISR;
                S_RD_MRCMDX0, S_RD_MRCMDX: w_addr = REG_MRCMDX;
                S_RD_HDR, S_RD_LEN, S_RD_DATA: begin
                    w_addr = REG_MRCMD;
                    w_type = COMMAND_RX;
                end
                S_DONE_BUS: begin
                    w_addr  = REG_ISR;
                    w_type  = COMMAND_WRITE;
                    w_dataw = ISR_CLEAR_RX;
                end
                default: w_addr = REG_NONE;
            endcase
        end
    end

    assign bus.rx_req_out                = (r_state != S_IDLE) && (r_state != S_DONE_BUS);
    assign bus.rx_start_comm_out         = (r_state == S_ISSUE);
    assign bus.rx_addr_out               = w_addr;
    assign bus.rx_comm_type_out          = w_type;
    assign bus.rx_dataw_out              = w_dataw;
    assign bus.rx_post_command_delay_out = NO_DELAY;
    assign bus.rx_packet_data_out        = w_word;
    assign bus.rx_packet_data_valid_out  = w_valid;
    assign bus.rx_packet_length_out      = r_length;
    assign bus.rx_complete_out           = r_complete;
    assign bus.rx_error_out              = r_error;
endmodule
